// File: rtl/counter_ctrl_pkg.sv
// Shared command/state encodings and the counter next-value function
// used by the command arbiter.
package counter_ctrl_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    CMD_CLEAR = 2'b00,
    CMD_UP    = 2'b01,
    CMD_DOWN  = 2'b10,
    CMD_LOAD  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  typedef struct packed {
    logic             wrap;
    logic [MAX_W-1:0] value;
  } cnt_res_t;

  // ones is the all-ones value of the real counter width, so wrap detection
  // works for any width up to MAX_W.
  function automatic cnt_res_t count_next(input cmd_e op, input logic [MAX_W-1:0] value,
                                          input logic [MAX_W-1:0] data,
                                          input logic [MAX_W-1:0] ones);
    cnt_res_t r;
    r.wrap  = 1'b0;
    r.value = value;
    case (op)
      CMD_CLEAR: r.value = '0;
      CMD_UP: begin
        if (value == ones) begin
          r.value = '0;
          r.wrap  = 1'b1;
        end else begin
          r.value = value + MAX_W'(1);
        end
      end
      CMD_DOWN: begin
        if (value == '0) begin
          r.value = ones;
          r.wrap  = 1'b1;
        end else begin
          r.value = value - MAX_W'(1);
        end
      end
      CMD_LOAD: r.value = data & ones;
      default:  r.value = value;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/counter_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester with req high, searching
// upward from last_grant+1 with wrap.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic [$clog2(N_REQ)-1:0] winner,
  output logic                     valid
);

  localparam int IDW = $clog2(N_REQ);

  logic [IDW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = IDW'((int'(last_grant) + i) % N_REQ);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/counter_cmd_arbiter.sv
// Shared event counter: round-robin IDLE/EXEC/ACK serialisation of requester
// commands (count and ack two cycles after sampling) plus idle-time autocount ticks.
module counter_cmd_arbiter
  import counter_ctrl_pkg::*;
#(
  parameter int                   N_REQ      = 4,
  parameter int                   WIDTH      = 8,
  parameter int                   DIV_WIDTH  = 24,
  parameter logic [DIV_WIDTH-1:0] DIV_RELOAD = 24'h100000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [2*N_REQ-1:0]       cmd,
  input  logic [WIDTH*N_REQ-1:0]   load_data,
  output logic [N_REQ-1:0]         ack,
  input  logic                     autocount_en,
  output logic [WIDTH-1:0]         count,
  output logic                     wrap,
  output logic                     eq_zero,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int               IDW  = $clog2(N_REQ);
  localparam logic [MAX_W-1:0] ONES = MAX_W'({WIDTH{1'b1}});

  state_e               state;
  logic [IDW-1:0]       last_grant;
  logic [IDW-1:0]       win_id;
  logic                 win_vld;
  cmd_e                 cmd_q;
  logic [WIDTH-1:0]     data_q;
  logic [DIV_WIDTH-1:0] div;
  logic                 tick_pending;
  logic                 tick_apply;
  cnt_res_t             exec_res;
  cnt_res_t             tick_res;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req),
    .last_grant(last_grant),
    .winner    (win_id),
    .valid     (win_vld)
  );

  assign exec_res   = count_next(cmd_q, MAX_W'(count), MAX_W'(data_q), ONES);
  assign tick_res   = count_next(CMD_UP, MAX_W'(count), '0, ONES);
  // A request always beats a pending tick; the tick waits for a quiet IDLE cycle.
  assign tick_apply = (state == ST_IDLE) && !win_vld && tick_pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      wrap       <= 1'b0;
      ack        <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
      last_grant <= IDW'(N_REQ - 1);
      cmd_q      <= CMD_CLEAR;
      data_q     <= '0;
    end else begin
      ack  <= '0;
      wrap <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            cmd_q    <= cmd_e'(cmd[2*win_id +: 2]);
            data_q   <= load_data[WIDTH*win_id +: WIDTH];
            grant_id <= win_id;
            busy     <= 1'b1;
            state    <= ST_EXEC;
          end else if (tick_apply) begin
            count <= WIDTH'(tick_res.value);
            wrap  <= tick_res.wrap;
          end
        end
        ST_EXEC: begin
          count         <= WIDTH'(exec_res.value);
          wrap          <= exec_res.wrap;
          ack[grant_id] <= 1'b1;
          state         <= ST_ACK;
        end
        ST_ACK: begin
          last_grant <= grant_id;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eq_zero <= 1'b1;
    end else begin
      eq_zero <= (count == '0);
    end
  end

  // Ticks coalesce into one pending flag; disabling autocount drops it on reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div          <= DIV_RELOAD;
      tick_pending <= 1'b0;
    end else if (div == '0) begin
      div          <= DIV_RELOAD;
      tick_pending <= autocount_en;
    end else begin
      div <= div - DIV_WIDTH'(1);
      if (tick_apply) begin
        tick_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Scoreboard bench for counter_cmd_arbiter: directed stimulus pushes expected
// ack/count events, a negedge monitor pops and compares them.
module tb_counter_cmd_arbiter;
  import counter_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  cmd;
  logic [31:0] load_data;
  logic        autocount_en;
  logic [3:0]  ack;
  logic [7:0]  count;
  logic        wrap;
  logic        eq_zero;
  logic        busy;
  logic [1:0]  grant_id;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         has_ack;
    int         gid;
    logic [7:0] cnt;
    logic       wr;
    int         dt;   // required cycles since previous event, 0 = unchecked
  } exp_t;

  exp_t       q[$];
  int         cyc        = 0;
  int         last_evt   = 0;
  logic [7:0] prev_count = 8'h00;

  always #5 clk = ~clk;

  counter_cmd_arbiter #(
    .N_REQ     (4),
    .WIDTH     (8),
    .DIV_WIDTH (24),
    .DIV_RELOAD(24'd3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .cmd         (cmd),
    .load_data   (load_data),
    .ack         (ack),
    .autocount_en(autocount_en),
    .count       (count),
    .wrap        (wrap),
    .eq_zero     (eq_zero),
    .busy        (busy),
    .grant_id    (grant_id)
  );

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic void expect_ack(input int id, input logic [7:0] c, input logic w, input int dt);
    q.push_back('{1'b1, id, c, w, dt});
  endfunction

  function automatic void expect_cnt(input logic [7:0] c, input int dt);
    q.push_back('{1'b0, 0, c, 1'b0, dt});
  endfunction

  // Monitor: an event is any ack pulse or any change of count.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (ack != 4'b0 || count != prev_count) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: ack=%b count=%0h wrap=%b, want no event", ack, count, wrap);
        end else begin
          e = q.pop_front();
          check("ack", int'(ack), e.has_ack ? (1 << e.gid) : 0);
          if (e.has_ack) check("grant_id", int'(grant_id), e.gid);
          check("count", int'(count), int'(e.cnt));
          check("wrap", int'(wrap), int'(e.wr));
          if (e.dt != 0) check("event_spacing", cyc - last_evt, e.dt);
        end
        last_evt = cyc;
      end else if (wrap) begin
        total++;
        bad++;
        $display("FAIL stray_wrap: wrap=1 with count steady at %0h, want 0", count);
      end
      prev_count = count;
    end
  end

  task automatic wait_ack(input int id);
    bit seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      seen = ack[id];
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: requester %0d got no ack in 40 cycles, want ack", id);
    end
  endtask

  task automatic wait_count(input logic [7:0] c);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = (count == c);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL count_timeout: count=%0h, want %0h within 60 cycles", count, c);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    check("queue_drained", q.size(), 0);
  endtask

  task automatic run_cmd(input int id, input logic [1:0] op, input logic [7:0] data);
    @(negedge clk);
    cmd[2*id +: 2]       = op;
    load_data[8*id +: 8] = data;
    req[id]              = 1'b1;
    wait_ack(id);
    req[id] = 1'b0;
  endtask

  task automatic do_reset(input logic auto_en);
    @(negedge clk);
    reset        = 1'b1;
    req          = 4'b0;
    autocount_en = auto_en;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    req          = 4'b0;
    cmd          = 8'h00;
    load_data    = 32'h0;
    autocount_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_eq_zero", int'(eq_zero), 1);
    check("rst_ack", int'(ack), 0);
    check("rst_wrap", int'(wrap), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_grant_id", int'(grant_id), 0);

    // Single up from requester 0: count/ack two cycles after sampling, eq_zero lags.
    expect_ack(0, 8'h01, 1'b0, 0);
    @(negedge clk);
    cmd[1:0] = CMD_UP;
    req[0]   = 1'b1;
    @(negedge clk);
    check("busy_exec", int'(busy), 1);
    wait_ack(0);
    check("eq_zero_lag", int'(eq_zero), 1);
    check("busy_ack", int'(busy), 1);
    req[0] = 1'b0;
    @(negedge clk);
    check("eq_zero_fall", int'(eq_zero), 0);
    check("busy_idle", int'(busy), 0);

    // Fresh pointer, then all four requesting; requester 1 re-requests a down.
    expect_cnt(8'h00, 0);
    do_reset(1'b0);
    expect_ack(0, 8'h01, 1'b0, 0);
    expect_ack(1, 8'h02, 1'b0, 3);
    expect_ack(2, 8'h03, 1'b0, 3);
    expect_ack(3, 8'h04, 1'b0, 3);
    expect_ack(1, 8'h03, 1'b0, 3);
    @(negedge clk);
    cmd = 8'h55;
    req = 4'hF;
    fork
      begin wait_ack(0); req[0] = 1'b0; end
      begin
        wait_ack(1);
        req[1] = 1'b0;
        @(negedge clk);
        cmd[3:2] = CMD_DOWN;
        req[1]   = 1'b1;
        wait_ack(1);
        req[1] = 1'b0;
      end
      begin wait_ack(2); req[2] = 1'b0; end
      begin wait_ack(3); req[3] = 1'b0; end
    join
    wait_drain();

    // Boundary arithmetic: wrap on up/down, never on load/clear.
    expect_ack(2, 8'hFF, 1'b0, 0); run_cmd(2, CMD_LOAD,  8'hFF);
    expect_ack(2, 8'h00, 1'b1, 0); run_cmd(2, CMD_UP,    8'h00);
    expect_ack(2, 8'hFF, 1'b1, 0); run_cmd(2, CMD_DOWN,  8'h00);
    expect_ack(2, 8'h00, 1'b0, 0); run_cmd(2, CMD_CLEAR, 8'h00);

    // cmd/load_data changed during EXEC are ignored.
    expect_ack(3, 8'h3C, 1'b0, 0);
    @(negedge clk);
    cmd[7:6]         = CMD_LOAD;
    load_data[31:24] = 8'h3C;
    req[3]           = 1'b1;
    @(negedge clk);
    load_data[31:24] = 8'hC3;
    cmd[7:6]         = CMD_CLEAR;
    wait_ack(3);
    req[3] = 1'b0;

    // Reset during EXEC of a load 5A: no ack, count cleared, requester 0 wins next.
    expect_cnt(8'h00, 0);
    @(negedge clk);
    cmd[1:0]       = CMD_LOAD;
    load_data[7:0] = 8'h5A;
    req[0]         = 1'b1;
    @(negedge clk);
    check("busy_before_abort", int'(busy), 1);
    reset = 1'b1;
    req   = 4'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_idle", int'(busy), 0);
    check("abort_grant_id", int'(grant_id), 0);
    expect_ack(0, 8'h01, 1'b0, 0);
    expect_ack(1, 8'h02, 1'b0, 3);
    @(negedge clk);
    cmd[3:0] = 4'b0101;
    req[1:0] = 2'b11;
    fork
      begin wait_ack(0); req[0] = 1'b0; end
      begin wait_ack(1); req[1] = 1'b0; end
    join
    wait_drain();

    // Autocount: one tick every 4 cycles; held requests defer and coalesce ticks.
    expect_cnt(8'h00, 0);
    do_reset(1'b1);
    expect_cnt(8'h01, 0);
    expect_cnt(8'h02, 4);
    expect_cnt(8'h03, 4);
    wait_count(8'h03);
    cmd[7:6] = CMD_CLEAR;
    req[3]   = 1'b1;
    expect_ack(3, 8'h00, 1'b0, 2);
    expect_ack(3, 8'h00, 1'b0, 3);
    expect_ack(3, 8'h00, 1'b0, 3);
    expect_ack(3, 8'h00, 1'b0, 3);
    expect_cnt(8'h01, 2);
    expect_cnt(8'h02, 3);
    repeat (4) wait_ack(3);
    req[3] = 1'b0;
    wait_count(8'h02);
    autocount_en = 1'b0;
    repeat (20) @(negedge clk);
    check("queue_empty_end", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
